// File: rtl/fpu_tb_pkg.sv
// Shared types and constants for the FP64 adder test pipe: field positions,
// flag indices, the queued expected-vector entry and the checker FSM state.
package fpu_tb_pkg;

  localparam int EXP_MSB  = 62;
  localparam int EXP_LSB  = 52;
  localparam int FRAC_MSB = 51;

  // IEEE exception flag bit positions within the 5-bit flags field
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] exp;
    logic [4:0]  flags;
  } tv_entry_t;

  localparam int ENTRY_W = $bits(tv_entry_t);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } chk_state_t;

endpackage

// File: rtl/tv_fifo.sv
// Parameterised synchronous circular-buffer FIFO with occupancy count;
// push when full and pop when empty are ignored.
module tv_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             tb_clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer increments wrap DEPTH-1 -> 0 naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge tb_clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge tb_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fpu_vector_checker.sv
// In-order scoreboard for the FP64 adder pipe: queues expected vectors, compares
// each returned DUT result, counts errors, flags protocol faults, reports done.
module fpu_vector_checker #(
  parameter int DEPTH       = 8,
  parameter bit CHECK_FLAGS = 1'b1,
  parameter bit NAN_EQUIV   = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             tb_clk,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [63:0]      issue_op1,
  input  logic [63:0]      issue_op2,
  input  logic [63:0]      issue_exp,
  input  logic [4:0]       issue_flags,
  input  logic             res_valid,
  input  logic [63:0]      res_result,
  input  logic [4:0]       res_flags,
  input  logic             end_of_test,
  output logic             mismatch,
  output logic [63:0]      mm_op1,
  output logic [63:0]      mm_op2,
  output logic [63:0]      mm_exp,
  output logic [63:0]      mm_got,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             protocol_err,
  output logic             done
);

  import fpu_tb_pkg::*;

  localparam int AW = $clog2(DEPTH);

  chk_state_t       state_q;
  logic             done_q;
  tv_entry_t        push_entry, head_entry;
  logic             fifo_full, fifo_empty;
  logic [AW:0]      occupancy;
  logic             push_en, pop_en;

  logic             cmp_valid_q;
  tv_entry_t        cmp_entry_q;
  logic [63:0]      cmp_res_q;
  logic [4:0]       cmp_flags_q;
  logic             exp_nan, got_nan, val_ok, flg_ok, cmp_fail;

  logic [CNT_W-1:0] vec_q, vec_d, err_q, err_d;
  logic             prot_q, prot_d;
  logic             mismatch_q;
  logic [63:0]      mm_op1_q, mm_op2_q, mm_exp_q, mm_got_q;

  assign push_entry  = {issue_op1, issue_op2, issue_exp, issue_flags};
  assign issue_ready = !fifo_full && (state_q == ST_RUN);
  assign push_en     = issue_valid && issue_ready;
  assign pop_en      = res_valid && !fifo_empty;

  tv_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .tb_clk  (tb_clk),
    .reset   (reset),
    .push_i  (push_en),
    .data_i  (push_entry),
    .pop_i   (pop_en),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

  // Popped entry and DUT response are registered so nothing downstream sees res_* directly
  always_ff @(posedge tb_clk) begin
    if (!reset) begin
      cmp_valid_q <= 1'b0;
      cmp_entry_q <= '0;
      cmp_res_q   <= '0;
      cmp_flags_q <= '0;
    end else begin
      cmp_valid_q <= pop_en;
      if (pop_en) begin
        cmp_entry_q <= head_entry;
        cmp_res_q   <= res_result;
        cmp_flags_q <= res_flags;
      end
    end
  end

  assign exp_nan  = (cmp_entry_q.exp[EXP_MSB:EXP_LSB] == 11'h7FF) && (cmp_entry_q.exp[FRAC_MSB:0] != '0);
  assign got_nan  = (cmp_res_q[EXP_MSB:EXP_LSB] == 11'h7FF) && (cmp_res_q[FRAC_MSB:0] != '0);
  assign val_ok   = (cmp_res_q == cmp_entry_q.exp) || (NAN_EQUIV && exp_nan && got_nan);
  assign flg_ok   = !CHECK_FLAGS || (cmp_flags_q == cmp_entry_q.flags);
  assign cmp_fail = cmp_valid_q && !(val_ok && flg_ok);

  always_comb begin
    vec_d  = vec_q;
    err_d  = err_q;
    prot_d = prot_q;
    if (cmp_valid_q && (vec_q != '1)) vec_d = vec_q + 1'b1;
    if (cmp_fail && (err_q != '1))    err_d = err_q + 1'b1;
    if (res_valid && (fifo_empty || (state_q == ST_DONE))) prot_d = 1'b1;
  end

  always_ff @(posedge tb_clk) begin
    if (!reset) begin
      vec_q      <= '0;
      err_q      <= '0;
      prot_q     <= 1'b0;
      mismatch_q <= 1'b0;
      mm_op1_q   <= '0;
      mm_op2_q   <= '0;
      mm_exp_q   <= '0;
      mm_got_q   <= '0;
    end else begin
      vec_q      <= vec_d;
      err_q      <= err_d;
      prot_q     <= prot_d;
      mismatch_q <= cmp_fail;
      if (cmp_fail) begin
        mm_op1_q <= cmp_entry_q.op1;
        mm_op2_q <= cmp_entry_q.op2;
        mm_exp_q <= cmp_entry_q.exp;
        mm_got_q <= cmp_res_q;
      end
    end
  end

  // Drain completes only once the last popped entry has also left the compare stage
  always_ff @(posedge tb_clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (end_of_test) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((occupancy == '0) && !cmp_valid_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mismatch     = mismatch_q;
  assign mm_op1       = mm_op1_q;
  assign mm_op2       = mm_op2_q;
  assign mm_exp       = mm_exp_q;
  assign mm_got       = mm_got_q;
  assign vec_count    = vec_q;
  assign err_count    = err_q;
  assign protocol_err = prot_q;
  assign done         = done_q;

endmodule

// File: tb/tb_fpu_vector_checker.sv
// Scoreboard bench for fpu_vector_checker: a default instance and a strict one
// (no NaN equivalence, flags ignored) share the same directed stimulus.
module tb_fpu_vector_checker;

  typedef struct {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] exp;
    logic [4:0]  flags;
  } issueT;

  typedef struct {
    logic [31:0] vec;
    logic [31:0] err;
    logic [31:0] errS;
    bit          mis;
    bit          misS;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] exp;
    logic [63:0] got;
  } expT;

  logic        tbClk = 1'b0;
  logic        reset = 1'b0;
  logic        issueValid = 1'b0;
  logic [63:0] issueOp1 = '0, issueOp2 = '0, issueExp = '0;
  logic [4:0]  issueFlags = '0;
  logic        resValid = 1'b0;
  logic [63:0] resResult = '0;
  logic [4:0]  resFlags = '0;
  logic        endOfTest = 1'b0;

  logic        issueReady, mismatch, protocolErr, done;
  logic [63:0] mmOp1, mmOp2, mmExp, mmGot;
  logic [31:0] vecCount, errCount;

  logic        issueReadyS, mismatchS, protocolErrS, doneS;
  logic [63:0] mmOp1S, mmOp2S, mmExpS, mmGotS;
  logic [31:0] vecCountS, errCountS;

  issueT       issuedQ[$];
  expT         sbQ[$];
  expT         monItem;
  int          checks = 0;
  int          errors = 0;
  int          vecModel = 0, errModel = 0, errModelS = 0;
  logic [31:0] prevVec = '0;

  always #5 tbClk = ~tbClk;

  fpu_vector_checker #(.DEPTH(8), .CHECK_FLAGS(1'b1), .NAN_EQUIV(1'b1), .CNT_W(32)) dut (
    .tb_clk(tbClk), .reset(reset),
    .issue_valid(issueValid), .issue_ready(issueReady),
    .issue_op1(issueOp1), .issue_op2(issueOp2), .issue_exp(issueExp), .issue_flags(issueFlags),
    .res_valid(resValid), .res_result(resResult), .res_flags(resFlags),
    .end_of_test(endOfTest), .mismatch(mismatch),
    .mm_op1(mmOp1), .mm_op2(mmOp2), .mm_exp(mmExp), .mm_got(mmGot),
    .vec_count(vecCount), .err_count(errCount),
    .protocol_err(protocolErr), .done(done)
  );

  fpu_vector_checker #(.DEPTH(8), .CHECK_FLAGS(1'b0), .NAN_EQUIV(1'b0), .CNT_W(32)) dutStrict (
    .tb_clk(tbClk), .reset(reset),
    .issue_valid(issueValid), .issue_ready(issueReadyS),
    .issue_op1(issueOp1), .issue_op2(issueOp2), .issue_exp(issueExp), .issue_flags(issueFlags),
    .res_valid(resValid), .res_result(resResult), .res_flags(resFlags),
    .end_of_test(endOfTest), .mismatch(mismatchS),
    .mm_op1(mmOp1S), .mm_op2(mmOp2S), .mm_exp(mmExpS), .mm_got(mmGotS),
    .vec_count(vecCountS), .err_count(errCountS),
    .protocol_err(protocolErrS), .done(doneS)
  );

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // One clock of stimulus; a result pairs with the oldest issued vector in the bench's own queue
  task automatic stepCycle(input bit doPush, input logic [63:0] op1, input logic [63:0] op2,
                           input logic [63:0] exp, input logic [4:0] flg,
                           input bit doRes, input logic [63:0] res, input logic [4:0] rflg,
                           input bit mis, input bit misS);
    issueT it;
    expT   e;
    @(posedge tbClk);
    #1;
    issueValid = doPush;
    issueOp1   = op1;
    issueOp2   = op2;
    issueExp   = exp;
    issueFlags = flg;
    resValid   = doRes;
    resResult  = res;
    resFlags   = rflg;
    if (doRes && (issuedQ.size() > 0)) begin
      it = issuedQ.pop_front();
      vecModel++;
      if (mis)  errModel++;
      if (misS) errModelS++;
      e.vec  = 32'(vecModel);
      e.err  = 32'(errModel);
      e.errS = 32'(errModelS);
      e.mis  = mis;
      e.misS = misS;
      e.op1  = it.op1;
      e.op2  = it.op2;
      e.exp  = it.exp;
      e.got  = res;
      sbQ.push_back(e);
    end
    if (doPush) begin
      it.op1   = op1;
      it.op2   = op2;
      it.exp   = exp;
      it.flags = flg;
      issuedQ.push_back(it);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] op1, input logic [63:0] op2,
                               input logic [63:0] exp, input logic [4:0] flg);
    stepCycle(1'b1, op1, op2, exp, flg, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic applyResult(input logic [63:0] res, input logic [4:0] rflg, input bit mis, input bit misS);
    stepCycle(1'b0, '0, '0, '0, '0, 1'b1, res, rflg, mis, misS);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge tbClk);
      #1;
      issueValid = 1'b0;
      resValid   = 1'b0;
    end
  endtask

  task automatic applyReset();
    @(posedge tbClk);
    #1;
    reset      = 1'b0;
    issueValid = 1'b0;
    resValid   = 1'b0;
    endOfTest  = 1'b0;
    @(posedge tbClk);
    #1;
    reset = 1'b1;
    issuedQ.delete();
    vecModel  = 0;
    errModel  = 0;
    errModelS = 0;
  endtask

  // Monitor: every counter step must match the next scoreboard entry; otherwise no mismatch pulse
  always @(negedge tbClk) begin
    if (!reset) begin
      prevVec = '0;
    end else if (vecCount != prevVec) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedCompare got vec_count=%0d want no change from %0d", vecCount, prevVec);
      end else begin
        monItem = sbQ.pop_front();
        checkOutput("vecCount", vecCount, monItem.vec);
        checkOutput("errCount", errCount, monItem.err);
        checkOutput("mismatch", mismatch, monItem.mis);
        checkOutput("vecCountStrict", vecCountS, monItem.vec);
        checkOutput("errCountStrict", errCountS, monItem.errS);
        checkOutput("mismatchStrict", mismatchS, monItem.misS);
        if (monItem.mis) begin
          checkOutput("mmOp1", mmOp1, monItem.op1);
          checkOutput("mmOp2", mmOp2, monItem.op2);
          checkOutput("mmExp", mmExp, monItem.exp);
          checkOutput("mmGot", mmGot, monItem.got);
        end
      end
      prevVec = vecCount;
    end else begin
      checkOutput("noSpuriousMismatch", {mismatch, mismatchS}, 2'b00);
    end
  end

  initial begin
    logic [63:0] one, two;
    int          pushIdx, popIdx;
    one = 64'h3FF0_0000_0000_0000;
    two = 64'h4000_0000_0000_0000;

    idleCycles(2);
    reset = 1'b1;
    checkOutput("resetIssueReady", issueReady, 1'b1);
    checkOutput("resetVecCount", vecCount, 0);
    checkOutput("resetErrCount", errCount, 0);
    checkOutput("resetProtocolErr", protocolErr, 1'b0);
    checkOutput("resetDone", done, 1'b0);
    checkOutput("resetMismatch", mismatch, 1'b0);

    // Basic match and value mismatch
    applyStimulus(one, one, two, 5'h00);
    idleCycles(2);
    applyResult(two, 5'h00, 1'b0, 1'b0);
    applyStimulus(one, one, two, 5'h00);
    idleCycles(2);
    applyResult(64'h4000_0000_0000_0001, 5'h00, 1'b1, 1'b1);
    idleCycles(3);

    // NaN equivalence, flags, infinities and the smallest-fraction NaN
    applyStimulus(64'h7FF0_0000_0000_0000, one, 64'h7FF8_0000_0000_0000, 5'h10);
    applyResult(64'hFFF8_0000_0000_0001, 5'h10, 1'b0, 1'b1);
    applyStimulus(one, one, two, 5'h01);
    applyResult(two, 5'h00, 1'b1, 1'b0);
    applyStimulus(64'h1, 64'h2, 64'h7FF0_0000_0000_0000, 5'h00);
    applyResult(64'hFFF0_0000_0000_0000, 5'h00, 1'b1, 1'b1);
    applyStimulus(64'h3, 64'h4, 64'h7FF8_0000_0000_0000, 5'h00);
    applyResult(64'h7FF0_0000_0000_0000, 5'h00, 1'b1, 1'b1);
    applyStimulus(64'h5, 64'h6, 64'h7FF0_0000_0000_0000, 5'h04);
    applyResult(64'h7FF0_0000_0000_0000, 5'h04, 1'b0, 1'b0);
    applyStimulus(64'h7, 64'h8, 64'h7FF0_0000_0000_0001, 5'h10);
    applyResult(64'h7FFF_FFFF_FFFF_FFFF, 5'h10, 1'b0, 1'b1);
    idleCycles(3);

    // Fill to full, try a 9th push, then lock-step push/pop across pointer wrap
    pushIdx = 0;
    popIdx  = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(64'(pushIdx), ~64'(pushIdx), two + 64'(pushIdx), 5'(pushIdx));
      pushIdx++;
    end
    idleCycles(1);
    checkOutput("fullIssueReady", issueReady, 1'b0);
    @(posedge tbClk);
    #1;
    issueValid = 1'b1;
    issueExp   = 64'hDEAD_BEEF_DEAD_BEEF;
    issueFlags = 5'h1F;
    checkOutput("ninthPushReady", issueReady, 1'b0);
    applyResult(two + 64'(popIdx), 5'(popIdx), 1'b0, 1'b0);
    popIdx++;
    for (int i = 0; i < 20; i++) begin
      stepCycle(1'b1, 64'(pushIdx), ~64'(pushIdx), two + 64'(pushIdx), 5'(pushIdx),
                1'b1, two + 64'(popIdx), 5'(popIdx), 1'b0, 1'b0);
      checkOutput("lockStepReady", issueReady, 1'b1);
      pushIdx++;
      popIdx++;
    end
    while (popIdx < 28) begin
      applyResult(two + 64'(popIdx), 5'(popIdx), 1'b0, 1'b0);
      popIdx++;
    end
    idleCycles(3);

    // Result with nothing queued
    applyResult(64'h1234, 5'h00, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("protocolErrEmpty", protocolErr, 1'b1);
    checkOutput("vecUnchangedEmpty", vecCount, 32'(vecModel));

    // End of test with three entries outstanding
    for (int i = 0; i < 3; i++) applyStimulus(64'(i), 64'(i), one + 64'(i), 5'h00);
    endOfTest = 1'b1;
    idleCycles(2);
    checkOutput("drainIssueReady", issueReady, 1'b0);
    checkOutput("drainDone", done, 1'b0);
    for (int i = 0; i < 3; i++) applyResult(one + 64'(i), 5'h00, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("doneNotEarly", done, 1'b0);
    checkOutput("vecAtLastCompare", vecCount, 32'(vecModel));
    idleCycles(1);
    checkOutput("doneRises", done, 1'b1);
    checkOutput("doneIssueReady", issueReady, 1'b0);

    // Reset with five entries queued
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(64'(i), 64'(i), two, 5'h00);
    applyReset();
    checkOutput("midResetIssueReady", issueReady, 1'b1);
    checkOutput("midResetVecCount", vecCount, 0);
    checkOutput("midResetErrCount", errCount, 0);
    checkOutput("midResetDone", done, 1'b0);
    checkOutput("midResetProtocolErr", protocolErr, 1'b0);
    applyResult(two, 5'h00, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("postResetProtocolErr", protocolErr, 1'b1);
    checkOutput("postResetVecCount", vecCount, 0);

    for (int i = 0; i < 20 && sbQ.size() > 0; i++) idleCycles(1);
    checkOutput("scoreboardDrained", sbQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
